// File: rtl/cache_arbiter.sv
// Shares one physical-memory line port between the I-cache and D-cache miss paths.
// Round-robin between requesters; a D writeback is held together with its refill.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_mem_read,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  output logic [LINE_WIDTH-1:0] i_mem_rdata,
  output logic                  i_mem_resp,
  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic                  d_mem_done,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [LINE_WIDTH-1:0] d_mem_wdata,
  output logic [LINE_WIDTH-1:0] d_mem_rdata,
  output logic                  d_mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    D_HOLD  = 2'd3
  } state_t;

  state_t r_state;
  logic   r_last_d;   // 1 when the D-cache completed the most recent transaction
  logic   w_i_req;
  logic   w_d_req;

  assign w_i_req = i_mem_read;
  assign w_d_req = d_mem_read | d_mem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_i_req && w_d_req) begin
            r_state <= r_last_d ? GRANT_I : GRANT_D;
          end else if (w_i_req) begin
            r_state <= GRANT_I;
          end else if (w_d_req) begin
            r_state <= GRANT_D;
          end
        end
        GRANT_I: begin
          if (pmem_resp) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
          end else if (!i_mem_read) begin
            r_state <= IDLE;
          end
        end
        GRANT_D: begin
          // A completed writeback keeps the port so the refill cannot be overtaken
          if (pmem_resp) begin
            if (d_mem_write) begin
              r_state <= D_HOLD;
            end else begin
              r_state  <= IDLE;
              r_last_d <= 1'b1;
            end
          end else if (!w_d_req) begin
            r_state <= IDLE;
          end
        end
        D_HOLD: begin
          if (d_mem_done) begin
            r_state <= GRANT_D;
          end else begin
            r_state  <= IDLE;
            r_last_d <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_mem_rdata = pmem_rdata;
  assign d_mem_rdata = pmem_rdata;

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_mem_resp   = 1'b0;
    d_mem_resp   = 1'b0;
    case (r_state)
      GRANT_I: begin
        pmem_read    = i_mem_read;
        pmem_address = i_mem_address;
        i_mem_resp   = pmem_resp;
      end
      GRANT_D: begin
        pmem_write   = d_mem_write;
        pmem_read    = d_mem_read & ~d_mem_write;
        pmem_address = d_mem_address;
        pmem_wdata   = d_mem_wdata;
        d_mem_resp   = pmem_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: behavioural memory, reactive cache requesters
// and a queue of expected transactions checked as each response completes.
module tb_cache_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk;
  logic          rst_n;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_address;
  logic [LW-1:0] i_mem_rdata;
  logic          i_mem_resp;
  logic          d_mem_read;
  logic          d_mem_write;
  logic          d_mem_done;
  logic [AW-1:0] d_mem_address;
  logic [LW-1:0] d_mem_wdata;
  logic [LW-1:0] d_mem_rdata;
  logic          d_mem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_done(d_mem_done),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          is_d;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } txn_t;

  txn_t exp_q[$];

  int passes = 0;
  int checks = 0;
  int fails  = 0;

  int            mem_cnt = 0;
  int            mem_lat = 2;
  logic [LW-1:0] mem_data = '0;
  logic          i_keep = 1'b0, d_keep = 1'b0;
  logic          i_seen = 1'b0, d_seen = 1'b0, d_done_nxt = 1'b0;
  logic [AW-1:0] refill_addr = '0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
    checks = checks + 1;
    assert (obs === expv) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic is_d, input logic wr, input logic [AW-1:0] addr,
                      input logic [LW-1:0] data);
    txn_t t;
    t.is_d = is_d; t.wr = wr; t.addr = addr; t.data = data;
    exp_q.push_back(t);
  endtask

  task automatic score();
    txn_t t;
    if (exp_q.size() == 0) begin
      chk("unexpected_resp", LW'({i_mem_resp, d_mem_resp}), LW'(0));
      return;
    end
    t = exp_q.pop_front();
    $display("resp: who=%s wr=%0d addr=%h", d_mem_resp ? "D" : "I", pmem_write, pmem_address);
    chk("resp_d", LW'(d_mem_resp), LW'(t.is_d));
    chk("resp_i", LW'(i_mem_resp), LW'(!t.is_d));
    chk("op_write", LW'(pmem_write), LW'(t.wr));
    chk("op_read", LW'(pmem_read), LW'(!t.wr));
    chk("addr", LW'(pmem_address), LW'(t.addr));
    if (t.wr) chk("wdata", pmem_wdata, t.data);
    else if (t.is_d) chk("d_rdata", d_mem_rdata, t.data);
    else chk("i_rdata", i_mem_rdata, t.data);
  endtask

  // One clock: requesters react to last cycle's resp, memory model advances, outputs scored.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (i_seen) begin
      i_seen = 1'b0;
      if (!i_keep) i_mem_read = 1'b0;
    end
    if (d_done_nxt) begin
      d_done_nxt    = 1'b0;
      d_mem_done    = 1'b0;
      d_mem_read    = 1'b1;
      d_mem_address = refill_addr;
    end
    if (d_seen) begin
      d_seen = 1'b0;
      if (d_mem_write) begin
        d_mem_write = 1'b0;
        d_mem_done  = 1'b1;
        d_done_nxt  = 1'b1;
      end else if (!d_keep) begin
        d_mem_read = 1'b0;
      end
    end
    pmem_resp = 1'b0;
    if (pmem_read || pmem_write) begin
      mem_cnt = mem_cnt + 1;
      if (mem_cnt >= mem_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = mem_data;
        mem_cnt    = 0;
      end
    end else begin
      mem_cnt = 0;
    end
    #1;
    if (d_done_nxt) begin
      chk("hold_no_pmem", LW'({pmem_read, pmem_write}), LW'(0));
      chk("hold_no_iresp", LW'(i_mem_resp), LW'(0));
    end
    if (i_mem_resp || d_mem_resp) score();
    if (i_mem_resp) i_seen = 1'b1;
    if (d_mem_resp) d_seen = 1'b1;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n = n + 1;
    end
    chk("drain", LW'(exp_q.size()), LW'(0));
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    i_mem_read = 1'b1; i_mem_address = 16'h1111;
    d_mem_read = 1'b0; d_mem_write = 1'b1; d_mem_done = 1'b0;
    d_mem_address = 16'h2222; d_mem_wdata = {8{16'hBEEF}};
    pmem_rdata = '0; pmem_resp = 1'b0;
    #13;
    chk("rst_pread", LW'(pmem_read), LW'(0));
    chk("rst_pwrite", LW'(pmem_write), LW'(0));
    chk("rst_paddr", LW'(pmem_address), LW'(0));
    chk("rst_pwdata", pmem_wdata, LW'(0));
    i_mem_read = 1'b0; d_mem_write = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cycle();

    // Lone I miss: request at cycle 0, memory answers in cycle 5
    mem_lat = 5; mem_data = {8{16'hA5A5}};
    i_mem_read = 1'b1; i_mem_address = 16'h1230;
    push(1'b0, 1'b0, 16'h1230, {8{16'hA5A5}});
    #1 chk("li_c0_idle", LW'(pmem_read), LW'(0));
    for (int c = 1; c <= 5; c++) begin
      cycle();
      chk("li_pread", LW'(pmem_read), LW'(1));
      chk("li_addr", LW'(pmem_address), LW'(16'h1230));
      chk("li_iresp", LW'(i_mem_resp), LW'(c == 5));
      chk("li_dresp", LW'(d_mem_resp), LW'(0));
    end
    cycle();
    chk("drain", LW'(exp_q.size()), LW'(0));

    // Asynchronous reset in the middle of an I transfer
    mem_lat = 20;
    i_mem_read = 1'b1; i_mem_address = 16'h0ABC;
    cycle(); cycle();
    chk("pre_rst_pread", LW'(pmem_read), LW'(1));
    #2 rst_n = 1'b0;
    #1 chk("async_pread", LW'(pmem_read), LW'(0));
    chk("async_paddr", LW'(pmem_address), LW'(0));
    i_mem_read = 1'b0;
    cycle(); cycle();
    #2 rst_n = 1'b1;
    cycle();
    chk("post_rst_out", LW'({pmem_read, pmem_write, i_mem_resp, d_mem_resp, pmem_address}), LW'(0));

    // Simultaneous requests after reset: D first, then I
    mem_lat = 3; mem_data = {8{16'h3C3C}};
    i_mem_read = 1'b1; i_mem_address = 16'h3000;
    d_mem_read = 1'b1; d_mem_address = 16'h2000;
    push(1'b1, 1'b0, 16'h2000, {8{16'h3C3C}});
    push(1'b0, 1'b0, 16'h3000, {8{16'h3C3C}});
    #1 chk("sim_c0_idle", LW'(pmem_read), LW'(0));
    cycle();
    chk("sim_c1_daddr", LW'(pmem_address), LW'(16'h2000));
    run(40);
    cycle(); cycle();

    // Dirty eviction: write 0x4000, hold, refill 0x8000, only then I
    mem_lat = 2; mem_data = {8{16'h5A5A}};
    d_mem_write = 1'b1; d_mem_address = 16'h4000; d_mem_wdata = {8{16'h1111}};
    refill_addr = 16'h8000;
    i_mem_read = 1'b1; i_mem_address = 16'h5000;
    push(1'b1, 1'b1, 16'h4000, {8{16'h1111}});
    push(1'b1, 1'b0, 16'h8000, {8{16'h5A5A}});
    push(1'b0, 1'b0, 16'h5000, {8{16'h5A5A}});
    run(60);
    cycle(); cycle();

    // Both held high for six transactions: D, I, D, I, D, I
    mem_lat = 2; mem_data = {8{16'h0F0F}};
    i_keep = 1'b1; d_keep = 1'b1;
    i_mem_read = 1'b1; i_mem_address = 16'h6000;
    d_mem_read = 1'b1; d_mem_address = 16'h7000;
    for (int k = 0; k < 3; k++) begin
      push(1'b1, 1'b0, 16'h7000, {8{16'h0F0F}});
      push(1'b0, 1'b0, 16'h6000, {8{16'h0F0F}});
    end
    run(80);
    i_mem_read = 1'b0; d_mem_read = 1'b0;
    i_keep = 1'b0; d_keep = 1'b0; i_seen = 1'b0; d_seen = 1'b0;
    cycle(); cycle();

    // Stray pmem_resp in IDLE is not forwarded
    pmem_resp = 1'b1;
    #1 chk("stray_iresp", LW'(i_mem_resp), LW'(0));
    chk("stray_dresp", LW'(d_mem_resp), LW'(0));
    cycle();
    chk("stray_idle", LW'({pmem_read, pmem_write, pmem_address}), LW'(0));
    i_mem_read = 1'b1; i_mem_address = 16'h0042;
    #1 chk("stray_still_idle", LW'(pmem_read), LW'(0));
    cycle();
    chk("stray_then_grant", LW'(pmem_read), LW'(1));
    i_mem_read = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
